// File: rtl/uart_alu_sequencer.sv
// Command sequencer between UART RX, a combinational ALU and UART TX: gathers
// operand 1, operand 2 and opcode bytes, then streams the ALU result back LSB byte first.
module uart_alu_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_OUT         = 16,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_OUT-1:0]  i_result,
    input  logic               i_tx_busy,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_operand1,
    output logic [NB_DATA-1:0] o_operand2,
    output logic [NB_OP-1:0]   o_opcode,
    output logic               o_operand1_ready,
    output logic               o_operand2_ready,
    output logic               o_opcode_ready,
    output logic               o_result_valid,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_timeout_err,
    output logic               o_overrun
);

    localparam int NB_RES_BYTES = (NB_OUT + NB_DATA - 1) / NB_DATA;
    localparam int NB_RES       = NB_RES_BYTES * NB_DATA;
    localparam int NB_IDX       = (NB_RES_BYTES > 1) ? $clog2(NB_RES_BYTES) : 1;
    localparam int NB_TO        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_OP2,
        WAIT_OPC,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t state, next_state;

    logic [NB_RES_BYTES-1:0][NB_DATA-1:0] result_q;
    logic [NB_IDX-1:0]                    byte_idx;
    logic [NB_TO-1:0]                     to_cnt;
    logic                                 waiting;
    logic                                 timeout_hit;
    logic                                 overrun_hit;
    logic                                 last_byte;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the same pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every signal written here gets a default first; a missing default on
    // any path would infer a latch.
    always_comb begin
        next_state  = state;
        o_tx_start  = 1'b0;
        waiting     = (state == WAIT_OP2) || (state == WAIT_OPC);
        // A byte arriving on the expiry cycle wins over the timeout.
        timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && !i_rx_done &&
                      (to_cnt == NB_TO'(TIMEOUT_CYCLES - 1));
        overrun_hit = i_rx_done && ((state == EXEC) || (state == SEND) || (state == WAIT_TX));
        last_byte   = (byte_idx == NB_IDX'(NB_RES_BYTES - 1));
        case (state)
            IDLE:     if (i_rx_done) next_state = WAIT_OP2;
            WAIT_OP2: if (i_rx_done) next_state = WAIT_OPC;
                      else if (timeout_hit) next_state = IDLE;
            WAIT_OPC: if (i_rx_done) next_state = EXEC;
                      else if (timeout_hit) next_state = IDLE;
            EXEC:     next_state = SEND;
            SEND: begin
                if (!i_tx_busy) begin
                    o_tx_start = 1'b1;
                    next_state = WAIT_TX;
                end
            end
            WAIT_TX:  if (i_tx_done) next_state = last_byte ? IDLE : SEND;
            default:  next_state = IDLE;
        endcase
    end

    // The selected byte stays on o_tx_data through WAIT_TX until the index advances.
    assign o_tx_data = result_q[byte_idx];

    // NOTE: the result register is reset as well, so o_tx_data reads zero out of
    // reset instead of stale contents from an aborted transfer.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_operand1       <= '0;
            o_operand2       <= '0;
            o_opcode         <= '0;
            o_operand1_ready <= 1'b0;
            o_operand2_ready <= 1'b0;
            o_opcode_ready   <= 1'b0;
            o_result_valid   <= 1'b0;
            o_busy           <= 1'b0;
            o_timeout_err    <= 1'b0;
            o_overrun        <= 1'b0;
            result_q         <= '0;
            byte_idx         <= '0;
            to_cnt           <= '0;
        end else begin
            o_result_valid <= 1'b0;
            o_busy         <= (next_state != IDLE);
            o_timeout_err  <= timeout_hit;
            o_overrun      <= overrun_hit;

            if (i_rx_done || !waiting || timeout_hit) to_cnt <= '0;
            else                                      to_cnt <= to_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (i_rx_done) begin
                        o_operand1       <= i_rx_data;
                        o_operand1_ready <= 1'b1;
                        o_operand2_ready <= 1'b0;
                        o_opcode_ready   <= 1'b0;
                    end
                end
                WAIT_OP2: begin
                    if (i_rx_done) begin
                        o_operand2       <= i_rx_data;
                        o_operand2_ready <= 1'b1;
                    end
                end
                WAIT_OPC: begin
                    if (i_rx_done) begin
                        o_opcode       <= i_rx_data[NB_OP-1:0];
                        o_opcode_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    result_q       <= NB_RES'(i_result);
                    o_result_valid <= 1'b1;
                    byte_idx       <= '0;
                end
                WAIT_TX: begin
                    if (i_tx_done && !last_byte) byte_idx <= byte_idx + 1'b1;
                end
                default: ;
            endcase

            // Leaving a command (completion or timeout) drops all ready flags.
            if ((state != IDLE) && (next_state == IDLE)) begin
                o_operand1_ready <= 1'b0;
                o_operand2_ready <= 1'b0;
                o_opcode_ready   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: table vectors, timeout/overrun/reset
// sequences and randomized commands against a reference ALU and byte-order model.
module tb_uart_alu_sequencer;

    localparam int NB_DATA   = 8;
    localparam int NB_OP     = 6;
    localparam int NB_OUT    = 16;
    localparam int TIMEOUT   = 20;
    localparam int RES_BYTES = 2;

    typedef struct {
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [7:0]  opc;
        logic [15:0] exp;
        int          gap;
        int          hold;
    } vec_t;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_OUT-1:0]  i_result;
    logic               i_tx_busy;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_operand1, o_operand2, o_tx_data;
    logic [NB_OP-1:0]   o_opcode;
    logic               o_operand1_ready, o_operand2_ready, o_opcode_ready;
    logic               o_result_valid, o_tx_start, o_busy, o_timeout_err, o_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_valid  = 0;
    int n_to     = 0;
    int n_ovr    = 0;

    uart_alu_sequencer #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_OUT(NB_OUT), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_result(i_result), .i_tx_busy(i_tx_busy), .i_tx_done(i_tx_done),
        .o_operand1(o_operand1), .o_operand2(o_operand2), .o_opcode(o_opcode),
        .o_operand1_ready(o_operand1_ready), .o_operand2_ready(o_operand2_ready),
        .o_opcode_ready(o_opcode_ready), .o_result_valid(o_result_valid),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
        .o_timeout_err(o_timeout_err), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    // Reference ALU: MIPS-like function codes on zero-extended 8-bit operands.
    function automatic logic [15:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
        case (op)
            6'h20, 6'h21: return {8'h00, a} + {8'h00, b};
            6'h22:        return {8'h00, a} - {8'h00, b};
            6'h24:        return {8'h00, a & b};
            6'h25:        return {8'h00, a | b};
            6'h26:        return {8'h00, a ^ b};
            default:      return {8'h00, a} * {8'h00, b};
        endcase
    endfunction

    assign i_result = ref_alu(o_operand1, o_operand2, o_opcode);

    logic [37:0] all_outs;
    assign all_outs = {o_operand1, o_operand2, o_opcode, o_operand1_ready, o_operand2_ready,
                       o_opcode_ready, o_result_valid, o_tx_start, o_tx_data, o_busy,
                       o_timeout_err, o_overrun};

    always @(negedge i_clk) begin
        if (o_tx_start)     n_starts++;
        if (o_result_valid) n_valid++;
        if (o_timeout_err)  n_to++;
        if (o_overrun)      n_ovr++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    // Full command: three bytes, then act as the transmitter for every result byte.
    task automatic run_cmd(input vec_t v, input bit ovr);
        int   s0, v0, t0, o0;
        logic seen;
        logic [15:0] e;
        s0 = n_starts; v0 = n_valid; t0 = n_to; o0 = n_ovr;
        e = v.exp;
        send_byte(v.op1);
        check("op1_capture", o_operand1, v.op1);
        check("flags_after_op1", {o_operand1_ready, o_operand2_ready, o_opcode_ready}, 3'b100);
        check("busy_after_op1", o_busy, 1'b1);
        repeat (v.gap) tick();
        send_byte(v.op2);
        check("op2_capture", o_operand2, v.op2);
        check("flags_after_op2", {o_operand1_ready, o_operand2_ready, o_opcode_ready}, 3'b110);
        repeat (v.gap) tick();
        i_tx_busy = (v.hold > 0);
        send_byte(v.opc);
        check("opc_capture", o_opcode, v.opc[5:0]);
        check("flags_after_opc", {o_operand1_ready, o_operand2_ready, o_opcode_ready}, 3'b111);
        check("valid_not_early", o_result_valid, 1'b0);
        tick();
        check("result_valid", o_result_valid, 1'b1);
        for (int k = 0; k < RES_BYTES; k++) begin
            seen = 1'b0;
            if (k == 0) begin
                for (int i = 0; i < v.hold; i++) begin
                    seen |= o_tx_start;
                    tick();
                end
            end
            check("no_start_while_busy", seen, 1'b0);
            i_tx_busy = 1'b0;
            #1;
            check("tx_start", o_tx_start, 1'b1);
            check("tx_data", o_tx_data, e[8*k +: 8]);
            tick();
            i_tx_busy = 1'b1;
            if (ovr && k == 0) begin
                send_byte(8'hAA);
                check("overrun_pulse", o_overrun, 1'b1);
                check("overrun_op1_kept", o_operand1, v.op1);
            end
            repeat (2) tick();
            check("tx_data_hold", {o_tx_start, o_tx_data}, {1'b0, e[8*k +: 8]});
            i_tx_busy = 1'b0;
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
        check("idle_busy", o_busy, 1'b0);
        check("idle_flags", {o_operand1_ready, o_operand2_ready, o_opcode_ready}, 3'b000);
        check("fields_hold", {o_operand1, o_operand2, o_opcode}, {v.op1, v.op2, v.opc[5:0]});
        check("start_count", n_starts - s0, RES_BYTES);
        check("valid_count", n_valid - v0, 1);
        check("timeout_count", n_to - t0, 0);
        check("overrun_count", n_ovr - o0, ovr ? 1 : 0);
    endtask

    // Send one or two bytes, then stay silent until the timeout fires.
    task automatic timeout_seq(input int nbytes);
        int   t0;
        logic seen;
        t0 = n_to;
        seen = 1'b0;
        for (int i = 0; i < nbytes; i++) send_byte(8'h05 + 8'(i));
        for (int i = 0; i < TIMEOUT; i++) begin
            seen |= o_timeout_err;
            tick();
        end
        check("timeout_not_early", seen, 1'b0);
        check("timeout_pulse", o_timeout_err, 1'b1);
        check("timeout_idle", {o_busy, o_operand1_ready, o_operand2_ready, o_opcode_ready}, 4'b0000);
        tick();
        check("timeout_width", o_timeout_err, 1'b0);
        check("timeout_count", n_to - t0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   s0;
        vecs[0] = '{8'h7F, 8'h01, 8'h20, 16'h0080, 0, 0};   // basic ADD
        vecs[1] = '{8'h7F, 8'h01, 8'h20, 16'h0080, 0, 40};  // TX busy held 40 cycles
        vecs[2] = '{8'h10, 8'h20, 8'hE2, 16'hFFF0, 19, 0};  // byte on the timeout cycle
        vecs[3] = '{8'h0C, 8'h0A, 8'h24, 16'h0008, 3, 2};
        vecs[4] = '{8'hFF, 8'hFF, 8'h3F, 16'hFE01, 1, 0};

        i_reset = 1'b0; i_rx_data = '0; i_rx_done = 1'b0; i_tx_busy = 1'b0; i_tx_done = 1'b0;
        #12;
        check("reset_outputs", all_outs, '0);
        tick();
        i_reset = 1'b1;
        tick();
        check("idle_after_reset", all_outs, '0);

        for (int i = 0; i < 5; i++) run_cmd(vecs[i], 1'b0);

        timeout_seq(1);
        run_cmd('{8'h09, 8'h0A, 8'h21, 16'h0013, 0, 0}, 1'b0);
        timeout_seq(2);

        run_cmd(vecs[0], 1'b1);
        run_cmd(vecs[3], 1'b0);

        // Reset while byte 0 is in flight: outputs clear at once, no later start.
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h20);
        tick();
        check("pre_reset_start", o_tx_start, 1'b1);
        tick();
        i_tx_busy = 1'b1;
        tick();
        #2;
        i_reset = 1'b0;
        #1;
        check("reset_mid_send", all_outs, '0);
        s0 = n_starts;
        tick();
        tick();
        i_reset = 1'b1;
        i_tx_busy = 1'b0;
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        repeat (10) tick();
        check("no_start_after_reset", n_starts - s0, 0);
        check("idle_after_mid_reset", all_outs, '0);

        for (int i = 0; i < 12; i++) begin
            v.op1  = 8'($urandom);
            v.op2  = 8'($urandom);
            v.opc  = 8'($urandom);
            v.exp  = ref_alu(v.op1, v.op2, v.opc[5:0]);
            v.gap  = $urandom_range(0, TIMEOUT - 1);
            v.hold = $urandom_range(0, 6);
            run_cmd(v, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
